// File: rtl/idex_buffer_pkg.sv
// Shared CPU package for the ID/EX stage.
// Provides the ALUOP class encodings, the control bundle captured by the ID/EX register,
// and the default datapath widths.
package idex_buffer_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned REG_W_DEF   = 16;
   localparam int unsigned FUNCT_W_DEF = 4;

   // ALU op class issued by the main control unit
   localparam logic [1:0] AluOpMem    = 2'b00;
   localparam logic [1:0] AluOpBranch = 2'b01;
   localparam logic [1:0] AluOpRType  = 2'b10;
   localparam logic [1:0] AluOpImm    = 2'b11;

   // Control bundle; all-zero is a NOP bubble
   typedef struct packed {
      logic       r15;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/idex_buffer_if.sv
// ID/EX stage bus.
// Carries the decode-stage inputs (read data, immediate, funct, source IDs, controls, flush)
// and the registered values presented to EX.
//   master : decode side, drives the *_in / data inputs and observes the *_out values
//   slave  : the ID/EX register itself
interface idex_buffer_if #(
   parameter int unsigned DATA_W  = idex_buffer_pkg::DATA_W_DEF,
   parameter int unsigned REG_W   = idex_buffer_pkg::REG_W_DEF,
   parameter int unsigned FUNCT_W = idex_buffer_pkg::FUNCT_W_DEF
);

   logic               IDEX_FLUSH;
   logic [DATA_W-1:0]  RD1;
   logic [DATA_W-1:0]  RD2;
   logic [DATA_W-1:0]  signExtendedR2;
   logic [FUNCT_W-1:0] funct_code_in;
   logic [REG_W-1:0]   IFID_RS;
   logic [REG_W-1:0]   IFID_RT;
   logic               R15_in;
   logic               ALUSrc_in;
   logic               MemToReg_in;
   logic               RegWrite_in;
   logic               MemRead_in;
   logic               MemWrite_in;
   logic               Branch_in;
   logic [1:0]         ALUOP_in;

   logic               R15_out;
   logic               ALUSrc_out;
   logic               MemToReg_out;
   logic               RegWrite_out;
   logic               MemRead_out;
   logic               MemWrite_out;
   logic               Branch_out;
   logic [1:0]         ALUOP_out;
   logic [DATA_W-1:0]  RD1_out;
   logic [DATA_W-1:0]  RD2_out;
   logic [DATA_W-1:0]  signExtendedR2_out;
   logic [FUNCT_W-1:0] funct_code_out;
   logic [REG_W-1:0]   IFID_RS_OUT;
   logic [REG_W-1:0]   IFID_RT_OUT;

   modport master (
      output IDEX_FLUSH, RD1, RD2, signExtendedR2, funct_code_in, IFID_RS, IFID_RT,
      output R15_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in,
      output ALUOP_in,
      input  R15_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out,
      input  Branch_out, ALUOP_out, RD1_out, RD2_out, signExtendedR2_out, funct_code_out,
      input  IFID_RS_OUT, IFID_RT_OUT
   );

   modport slave (
      input  IDEX_FLUSH, RD1, RD2, signExtendedR2, funct_code_in, IFID_RS, IFID_RT,
      input  R15_in, ALUSrc_in, MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in,
      input  ALUOP_in,
      output R15_out, ALUSrc_out, MemToReg_out, RegWrite_out, MemRead_out, MemWrite_out,
      output Branch_out, ALUOP_out, RD1_out, RD2_out, signExtendedR2_out, funct_code_out,
      output IFID_RS_OUT, IFID_RT_OUT
   );

endinterface

// File: rtl/idex_buffer_pipe_reg.sv
// Generic pipeline register.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears q to 0
//   clr : synchronous clear, loads 0 at the edge instead of d
//   d   : W-bit data in
//   q   : W-bit registered data out
module pipe_reg #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_d;
   logic [W-1:0] q_q;

   always_comb begin
      q_d = d;
      if (clr) begin
         q_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/idex_buffer.sv
// ID/EX pipeline register of the 16-bit pipelined CPU.
// Captures decode-stage data and the control bundle every edge and presents them to EX.
// IDEX_FLUSH zeroes only the control bundle, turning the captured instruction into a bubble.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears every output
//   bus : ID/EX stage bus (slave side), see idex_buffer_if
module idex_buffer
   import idex_buffer_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned REG_W   = REG_W_DEF,
   parameter int unsigned FUNCT_W = FUNCT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   idex_buffer_if.slave bus
);

   localparam int unsigned DataBits = 3 * DATA_W + FUNCT_W + 2 * REG_W;

   ctrl_t               ctrl_in;
   ctrl_t               ctrl_q;
   logic [DataBits-1:0] data_in;
   logic [DataBits-1:0] data_q;

   assign ctrl_in = '{
      r15:        bus.R15_in,
      alu_src:    bus.ALUSrc_in,
      mem_to_reg: bus.MemToReg_in,
      reg_write:  bus.RegWrite_in,
      mem_read:   bus.MemRead_in,
      mem_write:  bus.MemWrite_in,
      branch:     bus.Branch_in,
      aluop:      bus.ALUOP_in
   };

   assign data_in = {bus.RD1, bus.RD2, bus.signExtendedR2, bus.funct_code_in,
                     bus.IFID_RS, bus.IFID_RT};

   pipe_reg #(
      .W($bits(ctrl_t))
   ) u_ctrl_reg (
      .clk(clk),
      .rst(rst),
      .clr(bus.IDEX_FLUSH),
      .d  (ctrl_in),
      .q  (ctrl_q)
   );

   // Data and IDs load through a flush; with controls cleared they have no effect downstream
   pipe_reg #(
      .W(DataBits)
   ) u_data_reg (
      .clk(clk),
      .rst(rst),
      .clr(1'b0),
      .d  (data_in),
      .q  (data_q)
   );

   assign bus.R15_out      = ctrl_q.r15;
   assign bus.ALUSrc_out   = ctrl_q.alu_src;
   assign bus.MemToReg_out = ctrl_q.mem_to_reg;
   assign bus.RegWrite_out = ctrl_q.reg_write;
   assign bus.MemRead_out  = ctrl_q.mem_read;
   assign bus.MemWrite_out = ctrl_q.mem_write;
   assign bus.Branch_out   = ctrl_q.branch;
   assign bus.ALUOP_out    = ctrl_q.aluop;

   assign {bus.RD1_out, bus.RD2_out, bus.signExtendedR2_out, bus.funct_code_out,
           bus.IFID_RS_OUT, bus.IFID_RT_OUT} = data_q;

endmodule

// File: tb/tb_idex_buffer.sv
module tb_idex_buffer;
   import idex_buffer_pkg::*;

   typedef struct packed {
      logic        flush;
      ctrl_t       ctrl;
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic [15:0] sext;
      logic [3:0]  funct;
      logic [15:0] rs;
      logic [15:0] rt;
   } in_t;

   typedef struct packed {
      ctrl_t       ctrl;
      logic [15:0] rd1;
      logic [15:0] rd2;
      logic [15:0] sext;
      logic [3:0]  funct;
      logic [15:0] rs;
      logic [15:0] rt;
   } out_t;

   typedef struct {
      in_t  in;
      out_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   idex_buffer_if bus ();

   idex_buffer dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input in_t v);
      bus.IDEX_FLUSH     = v.flush;
      bus.R15_in         = v.ctrl.r15;
      bus.ALUSrc_in      = v.ctrl.alu_src;
      bus.MemToReg_in    = v.ctrl.mem_to_reg;
      bus.RegWrite_in    = v.ctrl.reg_write;
      bus.MemRead_in     = v.ctrl.mem_read;
      bus.MemWrite_in    = v.ctrl.mem_write;
      bus.Branch_in      = v.ctrl.branch;
      bus.ALUOP_in       = v.ctrl.aluop;
      bus.RD1            = v.rd1;
      bus.RD2            = v.rd2;
      bus.signExtendedR2 = v.sext;
      bus.funct_code_in  = v.funct;
      bus.IFID_RS        = v.rs;
      bus.IFID_RT        = v.rt;
   endtask

   function automatic out_t sample();
      out_t o;
      o.ctrl.r15        = bus.R15_out;
      o.ctrl.alu_src    = bus.ALUSrc_out;
      o.ctrl.mem_to_reg = bus.MemToReg_out;
      o.ctrl.reg_write  = bus.RegWrite_out;
      o.ctrl.mem_read   = bus.MemRead_out;
      o.ctrl.mem_write  = bus.MemWrite_out;
      o.ctrl.branch     = bus.Branch_out;
      o.ctrl.aluop      = bus.ALUOP_out;
      o.rd1             = bus.RD1_out;
      o.rd2             = bus.RD2_out;
      o.sext            = bus.signExtendedR2_out;
      o.funct           = bus.funct_code_out;
      o.rs              = bus.IFID_RS_OUT;
      o.rt              = bus.IFID_RT_OUT;
      return o;
   endfunction

   // Reference: one edge later the outputs equal the inputs, with the control bundle
   // replaced by a NOP when the edge was a flush.
   function automatic out_t model(input in_t v);
      out_t o;
      o.ctrl  = v.flush ? ctrl_t'(0) : v.ctrl;
      o.rd1   = v.rd1;
      o.rd2   = v.rd2;
      o.sext  = v.sext;
      o.funct = v.funct;
      o.rs    = v.rs;
      o.rt    = v.rt;
      return o;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t got;
      got = sample();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   // Rising edge, then step off it before sampling or driving
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t  tbl[6];
      in_t   base;
      in_t   v;
      ctrl_t c2;
      out_t  zero_o;
      out_t  e;

      zero_o = '0;
      c2 = '{r15: 1'b1, alu_src: 1'b0, mem_to_reg: 1'b1, reg_write: 1'b1, mem_read: 1'b0,
             mem_write: 1'b0, branch: 1'b0, aluop: AluOpImm};

      base = '{flush: 1'b0, ctrl: c2, rd1: 16'd3, rd2: 16'd7, sext: 16'd8, funct: 4'd2,
               rs: 16'd9, rt: 16'd4};

      tbl[0].in  = base;
      tbl[0].exp = '{ctrl: c2, rd1: 16'd3, rd2: 16'd7, sext: 16'd8, funct: 4'd2,
                     rs: 16'd9, rt: 16'd4};
      tbl[1].in  = base;
      tbl[1].in.flush = 1'b1;
      tbl[1].exp = '{ctrl: 9'h000, rd1: 16'd3, rd2: 16'd7, sext: 16'd8, funct: 4'd2,
                     rs: 16'd9, rt: 16'd4};
      tbl[2] = tbl[0];
      tbl[3] = tbl[1];
      tbl[4] = tbl[1];
      tbl[5].in = '{flush: 1'b0, ctrl: 9'h1FF, rd1: 16'hA5A5, rd2: 16'h5A5A, sext: 16'hFFF0,
                    funct: 4'hF, rs: 16'h000F, rt: 16'h0001};
      tbl[5].exp = '{ctrl: 9'h1FF, rd1: 16'hA5A5, rd2: 16'h5A5A, sext: 16'hFFF0, funct: 4'hF,
                     rs: 16'h000F, rt: 16'h0001};

      // Reset state with nonzero inputs, held across an edge
      drive(base);
      #1;
      check("reset_at_time0", zero_o);
      tick();
      check("reset_held_over_edge", zero_o);
      rst = 1'b0;

      // Pass-through, flush, alternating and consecutive flushes
      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].in);
         tick();
         check($sformatf("table_%0d", i), tbl[i].exp);
      end

      // Mid-cycle reset clears at once, stays clear until the next edge after release
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_midcycle", zero_o);
      rst = 1'b0;
      #1;
      check("reset_released_before_edge", zero_o);
      tick();
      check("first_edge_after_reset", tbl[5].exp);

      // Latency: input change between edges does not reach the outputs
      drive(base);
      tick();
      check("latency_load", model(base));
      v = base;
      v.rd1 = 16'hBEEF;
      drive(v);
      #2;
      check("latency_hold", model(base));
      tick();
      check("latency_next_edge", model(v));

      // Reset dominates flush with the clock running
      v = tbl[5].in;
      v.flush = 1'b1;
      drive(v);
      tick();
      check("flush_before_reset", model(v));
      rst = 1'b1;
      #1;
      check("reset_over_flush", zero_o);
      tick();
      check("reset_over_flush_edge1", zero_o);
      tick();
      check("reset_over_flush_edge2", zero_o);
      rst = 1'b0;
      v.flush = 1'b0;
      drive(v);
      tick();
      check("load_after_reset_flush", model(v));

      // Randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         v.flush = ($urandom_range(0, 3) == 0);
         v.ctrl  = ctrl_t'($urandom_range(0, 511));
         v.rd1   = 16'($urandom);
         v.rd2   = 16'($urandom);
         v.sext  = 16'($urandom);
         v.funct = 4'($urandom);
         v.rs    = 16'($urandom);
         v.rt    = 16'($urandom);
         drive(v);
         e = model(v);
         tick();
         check($sformatf("random_%0d", i), e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
